// File: rtl/breath_decoder.sv
// Breathing-light PWM lane decoder: locks onto the PWM frame, recovers each frame's
// 4-bit brightness, and tracks the breathing direction, turn-around points and lock.
module breath_decoder #(
    parameter int FRAME_LEN   = 16,
    parameter int CNT_W       = 5,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk_div_i,
    input  logic       rst_i,
    input  logic       pwm_i,
    output logic [3:0] bright_o,
    output logic       bright_vld_o,
    output logic       dark_o,
    output logic       dir_o,
    output logic       peak_o,
    output logic       locked_o
);

    localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam int LOW_W  = CNT_W + 1;

    typedef enum logic {
        HUNT,
        MEAS
    } state_t;

    state_t             state;
    logic               prev_pwm;
    logic [CNT_W-1:0]   frame_cnt;
    logic [CNT_W-1:0]   high_cnt;
    logic [CNT_W-1:0]   high_run;
    logic [LOW_W-1:0]   low_run;
    logic [GOOD_W-1:0]  good_cnt;
    logic [3:0]         prev_bright;

    logic               rise;
    logic               last_sample;
    logic [CNT_W-1:0]   total;
    logic [3:0]         bright_new;
    logic [GOOD_W-1:0]  good_next;

    always_comb begin
        rise        = pwm_i & ~prev_pwm;
        last_sample = (frame_cnt == CNT_W'(FRAME_LEN - 1));
        total       = high_cnt + CNT_W'(pwm_i);
        bright_new  = 4'(total - CNT_W'(1));
        good_next   = (good_cnt == GOOD_W'(LOCK_FRAMES)) ? good_cnt : good_cnt + GOOD_W'(1);
    end

    // prev_pwm keeps sampling through reset so a lane already high at release
    // is not mistaken for a frame start; it must then run FRAME_LEN highs.
    always_ff @(posedge clk_div_i) begin
        prev_pwm <= pwm_i;
        if (rst_i) begin
            state        <= HUNT;
            frame_cnt    <= '0;
            high_cnt     <= '0;
            high_run     <= '0;
            low_run      <= '0;
            good_cnt     <= '0;
            prev_bright  <= '0;
            bright_o     <= '0;
            bright_vld_o <= 1'b0;
            dark_o       <= 1'b0;
            dir_o        <= 1'b0;
            peak_o       <= 1'b0;
            locked_o     <= 1'b0;
        end else begin
            bright_vld_o <= 1'b0;
            peak_o       <= 1'b0;

            if (pwm_i) begin
                low_run <= '0;
                dark_o  <= 1'b0;
                if (high_run != CNT_W'(FRAME_LEN - 1)) begin
                    high_run <= high_run + CNT_W'(1);
                end
            end else begin
                high_run <= '0;
                if (low_run == LOW_W'(2 * FRAME_LEN - 1)) begin
                    dark_o <= 1'b1;
                end else begin
                    low_run <= low_run + LOW_W'(1);
                end
            end

            case (state)
                HUNT: begin
                    if (rise || (pwm_i && high_run == CNT_W'(FRAME_LEN - 1))) begin
                        state     <= MEAS;
                        frame_cnt <= CNT_W'(1);
                        high_cnt  <= CNT_W'(1);
                    end
                end
                MEAS: begin
                    if (frame_cnt == '0) begin
                        if (pwm_i) begin
                            frame_cnt <= CNT_W'(1);
                            high_cnt  <= CNT_W'(1);
                        end else begin
                            state    <= HUNT;
                            good_cnt <= '0;
                            locked_o <= 1'b0;
                        end
                    end else if (rise) begin
                        state     <= HUNT;
                        frame_cnt <= '0;
                        high_cnt  <= '0;
                        good_cnt  <= '0;
                        locked_o  <= 1'b0;
                    end else if (last_sample) begin
                        frame_cnt    <= '0;
                        high_cnt     <= '0;
                        bright_o     <= bright_new;
                        bright_vld_o <= 1'b1;
                        prev_bright  <= bright_new;
                        good_cnt     <= good_next;
                        locked_o     <= (good_next == GOOD_W'(LOCK_FRAMES));
                        if (good_cnt != '0) begin
                            if (bright_new > prev_bright) begin
                                dir_o  <= 1'b1;
                                peak_o <= ~dir_o;
                            end else if (bright_new < prev_bright) begin
                                dir_o  <= 1'b0;
                                peak_o <= dir_o;
                            end
                        end
                    end else begin
                        frame_cnt <= frame_cnt + CNT_W'(1);
                        high_cnt  <= total;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_breath_decoder.sv
// Directed bench for breath_decoder: drives hand-built PWM frames and compares
// every output against values worked out by hand from the frame patterns.
module tb_breath_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pwm = 1'b0;
    logic [3:0] bright;
    logic       bright_vld;
    logic       dark;
    logic       dir;
    logic       peak;
    logic       locked;

    int checks   = 0;
    int failures = 0;

    breath_decoder #(
        .FRAME_LEN  (16),
        .CNT_W      (5),
        .LOCK_FRAMES(2)
    ) dut (
        .clk_div_i   (clk),
        .rst_i       (rst),
        .pwm_i       (pwm),
        .bright_o    (bright),
        .bright_vld_o(bright_vld),
        .dark_o      (dark),
        .dir_o       (dir),
        .peak_o      (peak),
        .locked_o    (locked)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input logic v);
        pwm = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic lvl);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick(lvl);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] level(input int b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) if (i <= b) p[i] = 1'b1;
        return p;
    endfunction

    // Sample i of the frame is pat[i]; a valid frame pulses vld only on sample 15.
    task automatic send_pat(input string tag, input logic [15:0] pat, input logic exp_vld);
        int early;
        early = 0;
        for (int i = 0; i < 16; i++) begin
            tick(pat[i]);
            if (i < 15 && bright_vld) early++;
        end
        check({tag, "_vld_early"}, 32'(early), 32'd0);
        check({tag, "_vld_last"}, 32'(bright_vld), 32'(exp_vld));
    endtask

    function automatic logic [31:0] outs();
        return 32'({bright, bright_vld, dark, dir, peak, locked});
    endfunction

    initial begin
        int cnt;
        int first;
        int exp_b[7];
        int exp_dir[7];
        int exp_peak[7];

        // T1: reset with toggling lane, then toggling cannot form a frame
        rst = 1'b1;
        for (int i = 0; i < 3; i++) tick(logic'(i % 2));
        check("t1_reset_outs", outs(), 32'd0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick(logic'(i % 2));
            if (bright_vld) cnt++;
        end
        check("t1_no_vld", 32'(cnt), 32'd0);

        // T2: brightness 5 frames, lock after the second
        do_reset(1'b0);
        for (int f = 0; f < 4; f++) begin
            send_pat("t2", level(5), 1'b1);
            check("t2_bright", 32'(bright), 32'd5);
            check("t2_locked", 32'(locked), (f >= 1) ? 32'd1 : 32'd0);
        end
        check("t2_dir", 32'(dir), 32'd0);

        // T3: lane high through reset and after; frame starts at the 16th high,
        // so vld appears on samples 31 and 47 (visible during clocks 32 and 48)
        do_reset(1'b1);
        cnt   = 0;
        first = 0;
        for (int k = 1; k <= 48; k++) begin
            tick(1'b1);
            if (bright_vld) begin
                cnt++;
                if (first == 0) first = k;
                check("t3_bright", 32'(bright), 32'd15);
            end
        end
        check("t3_first_vld", 32'(first), 32'd31);
        check("t3_vld_count", 32'(cnt), 32'd2);
        check("t3_locked", 32'(locked), 32'd1);

        // T4: dark after 32 low samples, cleared by the next high sample
        do_reset(1'b0);
        for (int k = 0; k < 31; k++) tick(1'b0);
        check("t4_dark_31", 32'(dark), 32'd0);
        tick(1'b0);
        check("t4_dark_32", 32'(dark), 32'd1);
        for (int k = 0; k < 3; k++) tick(1'b0);
        check("t4_dark_hold", 32'(dark), 32'd1);
        tick(1'b1);
        check("t4_dark_clear", 32'(dark), 32'd0);

        // T5: descent then rise; peak on the 1-after-0 frame
        exp_b    = '{3, 2, 1, 0, 0, 1, 2};
        exp_dir  = '{0, 0, 0, 0, 0, 1, 1};
        exp_peak = '{0, 0, 0, 0, 0, 1, 0};
        do_reset(1'b0);
        for (int f = 0; f < 7; f++) begin
            send_pat("t5", level(exp_b[f]), 1'b1);
            check("t5_bright", 32'(bright), 32'(exp_b[f]));
            check("t5_dir", 32'(dir), 32'(exp_dir[f]));
            check("t5_peak", 32'(peak), 32'(exp_peak[f]));
        end

        // T6: glitch at sample 10 drops lock; two clean frames re-lock
        do_reset(1'b0);
        send_pat("t6a", level(4), 1'b1);
        send_pat("t6b", level(4), 1'b1);
        check("t6_locked_pre", 32'(locked), 32'd1);
        send_pat("t6_glitch", level(4) | 16'h0400, 1'b0);
        check("t6_locked_glitch", 32'(locked), 32'd0);
        send_pat("t6c", level(4), 1'b1);
        check("t6_locked_one", 32'(locked), 32'd0);
        check("t6_bright", 32'(bright), 32'd4);
        send_pat("t6d", level(4), 1'b1);
        check("t6_relocked", 32'(locked), 32'd1);

        // T7: reset at frame_cnt=8 discards the partial frame
        do_reset(1'b0);
        send_pat("t7", level(5), 1'b1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick(logic'(i <= 5));
            if (bright_vld) cnt++;
        end
        check("t7_partial_no_vld", 32'(cnt), 32'd0);
        rst = 1'b1;
        tick(1'b0);
        check("t7_reset_outs", outs(), 32'd0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
